// File: rtl/sd_img_responder.sv
// Responder side of the sector-level SD handshake: serves 512-byte sector reads/writes
// from a byte-wide image memory and issues the img_mounted/img_size mount notification.
module sd_img_responder #(
  parameter int IMG_AW  = 18,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_dout,
  output logic              sd_dout_strobe,
  input  logic [7:0]        sd_din,
  output logic              sd_din_strobe,
  input  logic              mount,
  input  logic [31:0]       mount_size,
  input  logic              wp,
  output logic              img_mounted,
  output logic [31:0]       img_size,
  output logic [IMG_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_d,
  input  logic [7:0]        mem_q,
  output logic              err
);

  localparam int PW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [PW-1:0] PH_RD_LAST = PW'(MEM_LAT);
  localparam logic [PW-1:0] PH_WR_LAST = PW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]        state;
  logic [9:0]        slot;        // byte slot 0..512; slot 512 is the closing cycle
  logic [PW-1:0]     phase;
  logic [IMG_AW-1:0] base_addr;
  logic              in_range;
  logic              wp_q;
  logic              mount_pending;
  logic [7:0]        wr_data;

  logic [40:0]       req_base;
  logic              req_oor;
  logic              take_mount;
  logic [8:0]        mem_idx;

  assign req_base   = {sd_lba, 9'b0};
  assign req_oor    = ({1'b0, req_base} + 42'd512) > {10'b0, img_size};
  assign take_mount = (state == ST_IDLE) && mount_pending;

  assign sd_ack        = (state != ST_IDLE);
  assign sd_din_strobe = (state == ST_WR) && (phase == PH_WR_LAST) && !slot[9];
  assign mem_rd        = (state == ST_RD) && (phase == '0) && !slot[9] && in_range;
  assign mem_wr        = (state == ST_WR) && (phase == '0) && (slot != '0) && in_range && !wp_q;

  // Writes land one slot after the byte was fetched from the initiator buffer.
  assign mem_idx  = (state == ST_WR) ? (slot[8:0] - 9'd1) : slot[8:0];
  assign mem_addr = base_addr + IMG_AW'(mem_idx);
  assign mem_d    = wr_data;

  // NOTE: state is updated only with non-blocking assignments, and the reset branch is
  // asynchronous so every output drops to 0 the moment res_n falls, even mid-transfer.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state          <= ST_IDLE;
      slot           <= '0;
      phase          <= '0;
      base_addr      <= '0;
      in_range       <= 1'b0;
      wp_q           <= 1'b0;
      mount_pending  <= 1'b0;
      wr_data        <= '0;
      sd_buff_addr   <= '0;
      sd_dout        <= '0;
      sd_dout_strobe <= 1'b0;
      img_mounted    <= 1'b0;
      img_size       <= '0;
      err            <= 1'b0;
    end else begin
      sd_dout_strobe <= 1'b0;
      img_mounted    <= 1'b0;

      // A fresh pulse always wins, so a mount landing on the take edge is not lost.
      if (mount)
        mount_pending <= 1'b1;
      else if (take_mount)
        mount_pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (take_mount) begin
            img_size    <= mount_size;
            err         <= 1'b0;
            img_mounted <= 1'b1;
          end else if (sd_rd || sd_wr) begin
            state        <= sd_rd ? ST_RD : ST_WR;
            base_addr    <= req_base[IMG_AW-1:0];
            in_range     <= !req_oor;
            wp_q         <= wp;
            slot         <= '0;
            phase        <= '0;
            sd_buff_addr <= '0;
            if (req_oor)
              err <= 1'b1;
          end
        end

        ST_RD: begin
          if (slot[9]) begin
            state <= ST_IDLE;
          end else if (phase == PH_RD_LAST) begin
            phase          <= '0;
            slot           <= slot + 10'd1;
            sd_dout        <= in_range ? mem_q : 8'h00;
            sd_dout_strobe <= 1'b1;
            sd_buff_addr   <= slot[8:0];
          end else begin
            phase <= phase + PW'(1);
          end
        end

        ST_WR: begin
          if (slot[9]) begin
            state <= ST_IDLE;
          end else if (phase == PH_WR_LAST) begin
            phase   <= '0;
            slot    <= slot + 10'd1;
            wr_data <= sd_din;
            if (slot[8:0] != 9'd511)
              sd_buff_addr <= slot[8:0] + 9'd1;
          end else begin
            phase <= phase + PW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_img_responder.sv
// Directed bench for sd_img_responder: a vector table of whole-sector transfers plus
// hand-written mount and reset sequences, against a small latency-accurate memory model.
module tb_sd_img_responder;

  localparam int IMG_AW  = 18;
  localparam int MEM_LAT = 2;
  localparam int P       = MEM_LAT + 1;

  logic              clk_sys = 1'b0;
  logic              res_n = 1'b0;
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_dout;
  logic              sd_dout_strobe;
  logic [7:0]        sd_din;
  logic              sd_din_strobe;
  logic              mount = 1'b0;
  logic [31:0]       mount_size = '0;
  logic              wp = 1'b0;
  logic              img_mounted;
  logic [31:0]       img_size;
  logic [IMG_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_d;
  logic [7:0]        mem_q;
  logic              err;

  logic [7:0] mem [0:4095];
  logic       mem_init = 1'b1;
  logic [7:0] q1;

  sd_img_responder #(.IMG_AW(IMG_AW), .MEM_LAT(MEM_LAT)) dut (
    .clk_sys(clk_sys), .res_n(res_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_dout(sd_dout),
    .sd_dout_strobe(sd_dout_strobe), .sd_din(sd_din), .sd_din_strobe(sd_din_strobe),
    .mount(mount), .mount_size(mount_size), .wp(wp), .img_mounted(img_mounted),
    .img_size(img_size), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_d(mem_d), .mem_q(mem_q), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // Image memory (pattern byte = addr[7:0]) with MEM_LAT=2 read pipeline, and the
  // initiator buffer returning ~index one cycle after sd_buff_addr.
  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
    end else if (mem_wr) begin
      mem[mem_addr[11:0]] <= mem_d;
    end
    q1     <= mem_rd ? mem[mem_addr[11:0]] : 8'hA5;
    mem_q  <= q1;
    sd_din <= ~sd_buff_addr[7:0];
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        wpv;
    logic        zero;
    logic [31:0] lba;
    logic [17:0] a0;
    int          e_ack;
    int          e_dstb;
    int          e_din;
    int          e_rd;
    int          e_wr;
    logic        e_err;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_errors = 0;
  int n_ack, n_dstb, n_din, n_rd, n_wr, n_bad, n_mnt, mnt_post;
  logic [31:0] size_post0, size_post1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One whole transfer, sampled at negedges; optional mount pulse when mount_at strobes seen.
  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] lba, input logic w,
                         input logic [17:0] a0, input logic zero, input int mount_at,
                         input logic [31:0] new_size);
    int cyc;
    int post;
    logic started, mnt_done;
    logic [17:0] ea;
    n_ack = 0; n_dstb = 0; n_din = 0; n_rd = 0; n_wr = 0; n_bad = 0; n_mnt = 0;
    mnt_post = -1; post = -1; started = 1'b0; mnt_done = 1'b0;
    size_post0 = '0; size_post1 = '0;
    @(negedge clk_sys);
    sd_lba = lba; wp = w; sd_rd = rd; sd_wr = wr;
    for (int t = 0; t < 4000 && post < 4; t++) begin
      @(negedge clk_sys);
      mount = 1'b0;
      cyc = n_ack;
      if (sd_ack) begin
        started = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0;
        n_ack++;
        if (sd_dout_strobe) begin
          ea = a0 + 18'(n_dstb);
          if (cyc != P * (n_dstb + 1) || sd_buff_addr != 9'(n_dstb) ||
              sd_dout != (zero ? 8'h00 : ea[7:0])) n_bad++;
          n_dstb++;
        end
        if (mem_rd) begin
          ea = a0 + 18'(n_rd);
          if (cyc != P * n_rd || mem_addr != ea) n_bad++;
          n_rd++;
        end
        if (sd_din_strobe) begin
          if (cyc != 2 * n_din + 1 || sd_buff_addr != 9'(n_din)) n_bad++;
          n_din++;
        end
        if (mem_wr) begin
          ea = a0 + 18'(n_wr);
          if (cyc != 2 * n_wr + 2 || mem_addr != ea || mem_d != ~8'(n_wr)) n_bad++;
          n_wr++;
        end
      end else begin
        if (sd_dout_strobe || sd_din_strobe || mem_rd || mem_wr) n_bad++;
        if (started) begin
          post++;
          if (post == 0) size_post0 = img_size;
          if (post == 1) size_post1 = img_size;
        end
      end
      if (img_mounted) begin
        n_mnt++;
        mnt_post = post;
      end
      if (mount_at >= 0 && !mnt_done && n_dstb == mount_at) begin
        mount_size = new_size; mount = 1'b1; mnt_done = 1'b1;
      end
    end
    mount = 1'b0;
    check("xfer_completed", 64'(post >= 4), 64'd1);
  endtask

  task automatic do_mount(input logic [31:0] sz, output int pulses);
    pulses = 0;
    @(negedge clk_sys);
    mount_size = sz; mount = 1'b1;
    @(negedge clk_sys);
    mount = 1'b0;
    repeat (6) begin
      @(negedge clk_sys);
      if (img_mounted) pulses++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, bad_w, bad_p;
    logic hit, mnt_done;
    logic [49:0] all_out;

    //           rd    wr    wp    zero  lba      a0          ack   dstb din  rd   wr   err
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd3,   18'd1536,   1537, 512, 0,   512, 0,   1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0,   18'd0,      1025, 0,   512, 0,   512, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd1,   18'd512,    1025, 0,   512, 0,   0,   1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd359, 18'd183808, 1537, 512, 0,   512, 0,   1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd360, 18'd0,      1537, 512, 0,   0,   0,   1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2,   18'd1024,   1537, 512, 0,   512, 0,   1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd400, 18'd0,      1025, 0,   512, 0,   0,   1'b1};

    // Reset state
    repeat (2) @(negedge clk_sys);
    all_out = {sd_ack, sd_buff_addr, sd_dout, sd_dout_strobe, sd_din_strobe, img_mounted,
               mem_rd, mem_wr, mem_d, err, mem_addr};
    check("reset_outputs", 64'(all_out), 64'd0);
    check("reset_img_size", 64'(img_size), 64'd0);
    mem_init = 1'b0;
    res_n = 1'b1;

    // Mount 184320
    do_mount(32'd184320, pulses);
    check("mount_pulses", 64'(pulses), 64'd1);
    check("mount_img_size", 64'(img_size), 64'd184320);
    check("mount_err", 64'(err), 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_xfer(vecs[i].rd, vecs[i].wr, vecs[i].lba, vecs[i].wpv, vecs[i].a0, vecs[i].zero,
              -1, 32'd0);
      check($sformatf("v%0d_ack_cycles", i), 64'(n_ack), 64'(vecs[i].e_ack));
      check($sformatf("v%0d_dout_strobes", i), 64'(n_dstb), 64'(vecs[i].e_dstb));
      check($sformatf("v%0d_din_strobes", i), 64'(n_din), 64'(vecs[i].e_din));
      check($sformatf("v%0d_mem_rd", i), 64'(n_rd), 64'(vecs[i].e_rd));
      check($sformatf("v%0d_mem_wr", i), 64'(n_wr), 64'(vecs[i].e_wr));
      check($sformatf("v%0d_timing_data", i), 64'(n_bad), 64'd0);
      check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      check($sformatf("v%0d_no_mount", i), 64'(n_mnt), 64'd0);
    end

    // Memory image after the LBA 0 write and the protected LBA 1 write
    bad_w = 0; bad_p = 0;
    for (int i = 0; i < 512; i++) if (mem[i] != ~8'(i)) bad_w++;
    for (int i = 512; i < 1024; i++) if (mem[i] != 8'(i)) bad_p++;
    check("mem_lba0_written", 64'(bad_w), 64'd0);
    check("mem_lba1_protected", 64'(bad_p), 64'd0);

    // A new mount clears the sticky error
    do_mount(32'd184320, pulses);
    check("remount_pulses", 64'(pulses), 64'd1);
    check("remount_err_cleared", 64'(err), 64'd0);

    // Mount arriving at byte 100 of a read is deferred to IDLE
    do_xfer(1'b1, 1'b0, 32'd6, 1'b0, 18'd3072, 1'b0, 100, 32'd368640);
    check("midmnt_ack_cycles", 64'(n_ack), 64'd1537);
    check("midmnt_dout_strobes", 64'(n_dstb), 64'd512);
    check("midmnt_timing_data", 64'(n_bad), 64'd0);
    check("midmnt_pulses", 64'(n_mnt), 64'd1);
    check("midmnt_pulse_cycle", 64'(mnt_post), 64'd1);
    check("midmnt_size_idle0", 64'(size_post0), 64'd184320);
    check("midmnt_size_idle1", 64'(size_post1), 64'd368640);

    // Reset at byte 200 of a read, with a mount pending since byte 150
    n_dstb = 0; hit = 1'b0; mnt_done = 1'b0;
    @(negedge clk_sys);
    sd_lba = 32'd4; sd_rd = 1'b1;
    for (int t = 0; t < 2000 && !hit; t++) begin
      @(negedge clk_sys);
      mount = 1'b0;
      if (sd_ack) sd_rd = 1'b0;
      if (sd_dout_strobe) n_dstb++;
      if (n_dstb == 150 && !mnt_done) begin
        mount_size = 32'd1000; mount = 1'b1; mnt_done = 1'b1;
      end
      if (n_dstb == 200) hit = 1'b1;
    end
    check("rst_reached_byte200", 64'(hit), 64'd1);
    check("rst_ack_before", 64'(sd_ack), 64'd1);
    #2 res_n = 1'b0;
    #1;
    all_out = {sd_ack, sd_buff_addr, sd_dout, sd_dout_strobe, sd_din_strobe, img_mounted,
               mem_rd, mem_wr, mem_d, err, mem_addr};
    check("rst_outputs_async", 64'(all_out), 64'd0);
    check("rst_img_size", 64'(img_size), 64'd0);
    repeat (3) @(negedge clk_sys);
    res_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (img_mounted) pulses++;
    end
    check("rst_pending_cleared", 64'(pulses), 64'd0);
    check("rst_size_still_zero", 64'(img_size), 64'd0);

    // Recover: mount, then read LBA 5
    do_mount(32'd184320, pulses);
    check("post_rst_mount", 64'(pulses), 64'd1);
    do_xfer(1'b1, 1'b0, 32'd5, 1'b0, 18'd2560, 1'b0, -1, 32'd0);
    check("post_rst_ack_cycles", 64'(n_ack), 64'd1537);
    check("post_rst_dout_strobes", 64'(n_dstb), 64'd512);
    check("post_rst_mem_rd", 64'(n_rd), 64'd512);
    check("post_rst_timing_data", 64'(n_bad), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_img_responder.md
# sd_img_responder

Responder end of the sector-level SD interface (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`) that the Oric core and FDC use as initiator. It serves 512-byte sector reads and writes from a byte-wide image memory (BRAM or an SDRAM port wrapper), so a disk image can be attached on-chip. It also generates the `img_mounted`/`img_size` mount notification. It sits between the FDC and the image memory in place of the SPI-driven IO-controller path.

## Interface
- `IMG_AW`, 18: image byte-address width; memory addresses are truncated to this width.
- `MEM_LAT`, 2: fixed memory read latency in cycles, minimum 1.

- `clk_sys`  in  1  system clock
- `res_n`  in  1  asynchronous, active-low reset
- `sd_lba`  in  32  sector number, sampled in IDLE
- `sd_rd` / `sd_wr`  in  1  read / write request (level)
- `sd_ack`  out  1  transfer in progress
- `sd_buff_addr`  out  9  byte index within the sector
- `sd_dout`  out  8  read data to the initiator
- `sd_dout_strobe`  out  1  one-cycle pulse: `sd_dout`/`sd_buff_addr` valid
- `sd_din`  in  8  write data from the initiator buffer; valid 1 cycle after `sd_buff_addr`
- `sd_din_strobe`  out  1  one-cycle pulse: `sd_din` is sampled this cycle
- `mount`  in  1  one-cycle pulse: a new image is present
- `mount_size`  in  32  image size in bytes; 0 means no image
- `wp`  in  1  write protect
- `img_mounted`  out  1  one-cycle mount notification
- `img_size`  out  32  registered image size
- `mem_addr`  out  IMG_AW  memory byte address
- `mem_rd` / `mem_wr`  out  1  one-cycle read / write strobes
- `mem_d`  out  8  write data
- `mem_q`  in  8  read data; valid `MEM_LAT` cycles after `mem_rd`
- `err`  out  1  sticky error: out-of-range access

## Operation
- Reset value of every output is 0.
- States: IDLE, RD, WR.
- **Request priority.** In IDLE, `sd_rd`=1 selects RD, else `sd_wr`=1 selects WR; if both are set, `sd_rd` wins. `sd_lba` is latched on that edge.
- **Sector byte base.** `{sd_lba,9'b0}` (41 bits).
- **Range check.** The sector is out of range when the 41-bit base + 512 > `img_size`. This is always the case when `img_size`=0.
  - On out of range: set `err`. No `mem_rd`/`mem_wr` is issued.
  - Reads return 0x00. Writes are discarded.
  - The handshake and timing are otherwise identical to an in-range transfer.
- **Write protect.** WR with `wp`=1 performs the full handshake but issues no `mem_wr`. `err` is unchanged.
- **Memory address.** `mem_addr` = (base + i) truncated to `IMG_AW` bits.
- **End of transfer.** After byte 511: `sd_ack`→0 and the state returns to IDLE. If a request is still high in IDLE, it starts a new transfer.
- **Mount.**
  - A `mount` pulse sets a pending flag.
  - In IDLE with the flag set: latch `mount_size` into `img_size`, clear `err`, and pulse `img_mounted` on the next cycle.
  - A mount that arrives during a transfer is deferred to IDLE and never lost.
  - Pending mounts are taken before new requests.
- **Reset mid-transfer.** The transfer is abandoned, all outputs go to 0 asynchronously, and the pending mount is cleared.

## Timing
- **Start.** c0 = the first cycle after the request-accepting edge. `sd_ack`=1 from c0.
- **Read, period P = `MEM_LAT`+1.**
  - `mem_rd` for byte i is in cycle c0+i·P.
  - `mem_q` is captured at the end of cycle c0+i·P+`MEM_LAT`.
  - `sd_dout`, `sd_buff_addr`=i and `sd_dout_strobe`=1 are in cycle c0+(i+1)·P. This overlaps with `mem_rd` for byte i+1.
  - `sd_ack` is high for 512·P+1 cycles. For `MEM_LAT`=2 that is 1537 cycles.
  - `sd_dout` holds its value between strobes.
- **Write, period 2.**
  - `sd_buff_addr`=i in cycle c0+2i, held for 2 cycles.
  - `sd_din_strobe`=1 in cycle c0+2i+1; `sd_din` is sampled at the end of that cycle.
  - `mem_wr`, `mem_d`, `mem_addr` for byte i are in cycle c0+2i+2.
  - `sd_ack` is high for 1025 cycles.
- **Strobes.** Every strobe is exactly one cycle wide. There is no backpressure from memory.
- **Minimum gap.** At least one IDLE cycle between consecutive transfers.

## Test plan
- **Mount and read in range.** `mount_size`=184320, then `mount` pulse.
  - `img_mounted` pulses once; `img_size`=184320.
  - Read LBA 3 with memory pattern byte = addr[7:0]: 512 strobes with `sd_buff_addr` 0..511, `sd_dout`=`sd_buff_addr`[7:0].
  - `mem_addr` runs 1536..2047; `sd_ack` is high for 1537 cycles.
- **Write LBA 0.** Initiator buffer holds byte = ~index: 512 `mem_wr` pulses at addresses 0..511 with `mem_d` = ~i[7:0]; `sd_ack` is high for 1025 cycles.
- **Write protect.** `wp`=1 and write LBA 1: 512 `sd_din_strobe` pulses, zero `mem_wr`, `err`=0, memory unchanged.
- **Out of range.** `img_size`=184320, read LBA 360: 512 strobes with data 0x00, no `mem_rd`, `err`=1. A subsequent `mount` clears `err`.
- **Simultaneous events and mid-transfer mount.**
  - `sd_rd` and `sd_wr` both high: RD is performed.
  - `mount` pulse at byte 100 of a read: the read completes unchanged, then `img_mounted` pulses 1 cycle after return to IDLE.
- **Reset mid-read.** `res_n`=0 at byte 200: all outputs are 0 immediately. After release, a new read of LBA 5 completes normally.
